// File: rtl/memory_access_unit.sv
// Memory-stage load/store unit: IDLE/REQ/DONE handshake with a req/ack data bus.
// Optional misalignment trap enabled by defining MEM_ACCESS_MISALIGN_CHECK_EN.
module memory_access_unit #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [1:0]            ResultSrcM,
   input  logic                  MemWriteM,
   input  logic [DATA_WIDTH-1:0] ALUResultM,
   input  logic [DATA_WIDTH-1:0] WriteDataM,
   input  logic [2:0]            AddressingControlM,
   output logic                  StallM,
   output logic [DATA_WIDTH-1:0] ReadDataM,
   output logic                  MisalignM,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [DATA_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   output logic [3:0]            mem_be,
   input  logic                  mem_ack,
   input  logic [DATA_WIDTH-1:0] mem_rdata
);

   typedef enum logic [1:0] {IDLE = 2'b00, REQ = 2'b01, DONE = 2'b10} state_t;

   state_t      state_q, state_d;
   logic        access_s, misalign_s, stall_s;
   logic        mem_req_q, mem_we_q, misalign_q;
   logic [31:0] mem_addr_q, mem_wdata_q, rdata_q;
   logic [3:0]  mem_be_q;
   logic [1:0]  addr_lo_q;
   logic [2:0]  f3_q;

   function automatic logic [3:0] calc_be(input logic [2:0] f3, input logic [1:0] a);
      case (f3[1:0])
         2'b00:   calc_be = 4'b0001 << a;
         2'b01:   calc_be = 4'b0011 << {a[1], 1'b0};
         default: calc_be = 4'b1111;
      endcase
   endfunction

   function automatic logic [31:0] rep_wdata(input logic [2:0] f3, input logic [31:0] wd);
      case (f3[1:0])
         2'b00:   rep_wdata = {4{wd[7:0]}};
         2'b01:   rep_wdata = {2{wd[15:0]}};
         default: rep_wdata = wd;
      endcase
   endfunction

   // Lane selection follows the low address bits; funct3[2] picks zero-extension.
   function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [1:0] a,
                                            input logic [31:0] w);
      logic [7:0]  b;
      logic [15:0] h;
      b = 8'(w >> {a, 3'b000});
      h = 16'(w >> {a[1], 4'b0000});
      case (f3[1:0])
         2'b00:   load_ext = f3[2] ? {24'h000000, b} : {{24{b[7]}}, b};
         2'b01:   load_ext = f3[2] ? {16'h0000, h} : {{16{h[15]}}, h};
         default: load_ext = w;
      endcase
   endfunction

   assign access_s = (ResultSrcM == 2'b01) || MemWriteM;

`ifdef MEM_ACCESS_MISALIGN_CHECK_EN
   assign misalign_s = ((AddressingControlM[1:0] == 2'b01) && ALUResultM[0]) ||
                       (AddressingControlM[1]   && (ALUResultM[1:0] != 2'b00));
`else
   assign misalign_s = 1'b0;
`endif

   // Next-state and stall decode.
   always_comb begin
      state_d = state_q;
      stall_s = 1'b0;
      case (state_q)
         IDLE: begin
            if (access_s) begin
               stall_s = 1'b1;
               state_d = misalign_s ? DONE : REQ;
            end else begin
               state_d = IDLE;
            end
         end
         REQ: begin
            stall_s = 1'b1;
            if (mem_ack) begin
               state_d = DONE;
            end else begin
               state_d = REQ;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State, bus fields and load result registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= 32'h0000_0000;
         mem_wdata_q <= 32'h0000_0000;
         mem_be_q    <= 4'b0000;
         addr_lo_q   <= 2'b00;
         f3_q        <= 3'b000;
         rdata_q     <= 32'h0000_0000;
         misalign_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         misalign_q <= (state_q == IDLE) && access_s && misalign_s;
         case (state_q)
            IDLE: begin
               if (access_s && !misalign_s) begin
                  mem_req_q   <= 1'b1;
                  mem_we_q    <= MemWriteM;
                  mem_addr_q  <= {ALUResultM[31:2], 2'b00};
                  mem_wdata_q <= rep_wdata(AddressingControlM, WriteDataM);
                  mem_be_q    <= calc_be(AddressingControlM, ALUResultM[1:0]);
                  addr_lo_q   <= ALUResultM[1:0];
                  f3_q        <= AddressingControlM;
               end
            end
            REQ: begin
               if (mem_ack) begin
                  mem_req_q <= 1'b0;
                  if (!mem_we_q) begin
                     rdata_q <= load_ext(f3_q, addr_lo_q, mem_rdata);
                  end
               end
            end
            default: mem_req_q <= 1'b0;
         endcase
      end
   end

   assign StallM    = stall_s;
   assign ReadDataM = rdata_q;
   assign MisalignM = misalign_q;
   assign mem_req   = mem_req_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign mem_be    = mem_be_q;

endmodule

// File: tb/tb_memory_access_unit.sv
// Directed self-checking bench for memory_access_unit; expected values are hand-computed.
module tb_memory_access_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [1:0]  ResultSrcM;
   logic        MemWriteM;
   logic [31:0] ALUResultM, WriteDataM;
   logic [2:0]  AddressingControlM;
   logic        StallM, MisalignM, mem_req, mem_we, mem_ack;
   logic [31:0] ReadDataM, mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  mem_be;

   int checks = 0;
   int errors = 0;

   int          n_stall, n_req;
   logic [3:0]  be_seen;
   logic [31:0] addr_seen, wdata_seen;
   logic        we_seen, mis_seen;

   memory_access_unit #(.DATA_WIDTH(32)) dut (
      .clk(clk), .rst_n(rst_n), .ResultSrcM(ResultSrcM), .MemWriteM(MemWriteM),
      .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
      .AddressingControlM(AddressingControlM), .StallM(StallM), .ReadDataM(ReadDataM),
      .MisalignM(MisalignM), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Present one access, answer the bus after ack_delay wait cycles, stop at the first unstalled cycle.
   task automatic run_access(input logic ld, input logic we, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] wd,
                             input logic [31:0] rd, input int ack_delay);
      int w;
      bit done;
      n_stall = 0; n_req = 0; w = 0; done = 0;
      be_seen = 4'h0; addr_seen = 32'h0; wdata_seen = 32'h0; we_seen = 1'b0; mis_seen = 1'b0;
      @(negedge clk);
      ResultSrcM = ld ? 2'b01 : 2'b00;
      MemWriteM = we; AddressingControlM = f3; ALUResultM = addr; WriteDataM = wd;
      mem_rdata = rd; mem_ack = 1'b0;
      for (int c = 0; c < 40; c++) begin
         #1;
         if (MisalignM) mis_seen = 1'b1;
         if (!StallM) begin
            done = 1;
            break;
         end
         n_stall++;
         if (mem_req) begin
            n_req++;
            be_seen = mem_be; addr_seen = mem_addr; wdata_seen = mem_wdata; we_seen = mem_we;
            mem_ack = (w >= ack_delay);
            w++;
         end else begin
            mem_ack = 1'b0;
         end
         @(negedge clk);
      end
      check("access_completes", {31'd0, done}, 32'd1);
      mem_ack = 1'b0; ResultSrcM = 2'b00; MemWriteM = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; ResultSrcM = 2'b00; MemWriteM = 1'b0; ALUResultM = 32'h0;
      WriteDataM = 32'h0; AddressingControlM = 3'b000; mem_ack = 1'b0; mem_rdata = 32'h0;
      repeat (2) @(negedge clk);
      #1;
      check("rst_mem_req",   {31'd0, mem_req},   32'd0);
      check("rst_mem_we",    {31'd0, mem_we},    32'd0);
      check("rst_mem_addr",  mem_addr,           32'h0);
      check("rst_mem_wdata", mem_wdata,          32'h0);
      check("rst_mem_be",    {28'd0, mem_be},    32'd0);
      check("rst_readdata",  ReadDataM,          32'h0);
      check("rst_misalign",  {31'd0, MisalignM}, 32'd0);
      check("rst_stall",     {31'd0, StallM},    32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Non-access instruction in IDLE
      @(negedge clk);
      ResultSrcM = 2'b10; ALUResultM = 32'h0000_0104;
      #1 check("nonaccess_stall", {31'd0, StallM}, 32'd0);
      @(negedge clk);
      #1 check("nonaccess_req", {31'd0, mem_req}, 32'd0);
      ResultSrcM = 2'b00;

      // Store word
      run_access(1'b0, 1'b1, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0, 0);
      check("sw_stall", n_stall,           32'd2);
      check("sw_req",   n_req,             32'd1);
      check("sw_be",    {28'd0, be_seen},  32'hF);
      check("sw_addr",  addr_seen,         32'h0000_0100);
      check("sw_we",    {31'd0, we_seen},  32'd1);
      check("sw_wdata", wdata_seen,        32'hDEAD_BEEF);
      @(negedge clk);
      #1 check("sw_req_after", {31'd0, mem_req}, 32'd0);

      // Store byte at lane 3
      run_access(1'b0, 1'b1, 3'b000, 32'h0000_0103, 32'h0000_00A5, 32'h0, 0);
      check("sb_be",    {28'd0, be_seen}, 32'h8);
      check("sb_wdata", wdata_seen,       32'hA5A5_A5A5);
      check("sb_addr",  addr_seen,        32'h0000_0100);

      // LB / LBU at 0x102
      run_access(1'b1, 1'b0, 3'b000, 32'h0000_0102, 32'h0, 32'h12F4_5678, 0);
      check("lb_data", ReadDataM,       32'hFFFF_FFF4);
      check("lb_we",   {31'd0, we_seen}, 32'd0);
      check("lb_be",   {28'd0, be_seen}, 32'h4);
      run_access(1'b1, 1'b0, 3'b100, 32'h0000_0102, 32'h0, 32'h12F4_5678, 0);
      check("lbu_data", ReadDataM, 32'h0000_00F4);

      // LH with ack delayed 3 cycles
      run_access(1'b1, 1'b0, 3'b001, 32'h0000_0102, 32'h0, 32'h8001_5678, 3);
      check("lh_req",   n_req,           32'd4);
      check("lh_stall", n_stall,         32'd5);
      check("lh_data",  ReadDataM,       32'hFFFF_8001);
      check("lh_be",    {28'd0, be_seen}, 32'hC);

      // Load+store together is a store; ReadDataM untouched
      run_access(1'b1, 1'b1, 3'b010, 32'h0000_0108, 32'h0BAD_F00D, 32'h5555_5555, 0);
      check("both_we",      {31'd0, we_seen}, 32'd1);
      check("store_keeps_rd", ReadDataM,      32'hFFFF_8001);

      // Reset during REQ
      @(negedge clk);
      ResultSrcM = 2'b01; AddressingControlM = 3'b010; ALUResultM = 32'h0000_0200;
      @(negedge clk);
      #1 check("mid_req_before", {31'd0, mem_req}, 32'd1);
      rst_n = 1'b0;
      #1;
      check("mid_rst_req",   {31'd0, mem_req}, 32'd0);
      check("mid_rst_rd",    ReadDataM,        32'h0);
      check("mid_rst_addr",  mem_addr,         32'h0);
      check("mid_rst_stall", {31'd0, StallM},  32'd1);
      ResultSrcM = 2'b00;
      @(negedge clk);
      rst_n = 1'b1;
      run_access(1'b1, 1'b0, 3'b010, 32'h0000_0104, 32'h0, 32'hCAFE_F00D, 1);
      check("post_rst_req",   n_req,     32'd2);
      check("post_rst_stall", n_stall,   32'd3);
      check("post_rst_data",  ReadDataM, 32'hCAFE_F00D);

      // Misaligned LW at 0x102
      run_access(1'b1, 1'b0, 3'b010, 32'h0000_0102, 32'h0, 32'h1122_3344, 0);
`ifdef MEM_ACCESS_MISALIGN_CHECK_EN
      check("mis_req",   n_req,              32'd0);
      check("mis_stall", n_stall,            32'd1);
      check("mis_flag",  {31'd0, mis_seen},  32'd1);
      check("mis_rd",    ReadDataM,          32'hCAFE_F00D);
`else
      check("mis_req",   n_req,              32'd1);
      check("mis_stall", n_stall,            32'd2);
      check("mis_flag",  {31'd0, mis_seen},  32'd0);
      check("mis_rd",    ReadDataM,          32'h1122_3344);
`endif
      @(negedge clk);
      #1 check("mis_flag_clear", {31'd0, MisalignM}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
